// File: rtl/draw_scheduler.sv
// Frame-level sequencer: grants the shared VGA plot port to each enabled drawing engine
// in index order, muxes its pixel stream, and flags watchdog releases and frame overruns.
module draw_scheduler #(
   parameter int NUM_CLIENTS    = 3,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 12
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic [NUM_CLIENTS-1:0]   client_enable,
   input  logic                     clear_err,
   input  logic [NUM_CLIENTS-1:0]   client_finish,
   input  logic [8*NUM_CLIENTS-1:0] client_x,
   input  logic [7*NUM_CLIENTS-1:0] client_y,
   input  logic [3*NUM_CLIENTS-1:0] client_color,
   output logic [NUM_CLIENTS-1:0]   client_draw,
   output logic [7:0]               x,
   output logic [6:0]               y,
   output logic [2:0]               color,
   output logic                     plot,
   output logic                     busy,
   output logic                     frame_done,
   output logic [NUM_CLIENTS-1:0]   timeout_err,
   output logic                     overrun
);
   localparam int IDX_W = $clog2(NUM_CLIENTS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FIN_MIN = CNT_W'(2);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CLIENTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_DRAW,
      S_GAP,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_CLIENTS-1:0] mask_q, mask_d;
   logic [NUM_CLIENTS-1:0] terr_q, terr_d;
   logic                   ovr_q, ovr_d;
   logic [7:0]             x_q;
   logic [6:0]             y_q;
   logic [2:0]             color_q;

   logic [7:0] cx [NUM_CLIENTS];
   logic [6:0] cy [NUM_CLIENTS];
   logic [2:0] cc [NUM_CLIENTS];

   for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign cx[gi] = client_x[8*gi +: 8];
      assign cy[gi] = client_y[7*gi +: 7];
      assign cc[gi] = client_color[3*gi +: 3];
   end

   // Granted client's finish and pixel slice, plus its one-hot grant vector.
   logic [NUM_CLIENTS-1:0] grant_oh;
   logic                   fin_sel;
   logic [7:0]             x_sel;
   logic [6:0]             y_sel;
   logic [2:0]             color_sel;

   always_comb begin
      grant_oh  = '0;
      fin_sel   = 1'b0;
      x_sel     = '0;
      y_sel     = '0;
      color_sel = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (grant_q == IDX_W'(k)) begin
            grant_oh[k] = 1'b1;
            fin_sel     = client_finish[k];
            x_sel       = cx[k];
            y_sel       = cy[k];
            color_sel   = cc[k];
         end
      end
   end

   // Lowest enabled client at or above the scan start; descending loop so the lowest wins.
   logic             found;
   logic [IDX_W-1:0] sel_idx;

   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         if (mask_q[k] && (IDX_W'(k) >= idx_q)) begin
            found   = 1'b1;
            sel_idx = IDX_W'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      terr_d  = clear_err ? '0 : terr_q;
      ovr_d   = clear_err ? 1'b0 : ovr_q;

      if (frame_tick && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               mask_d  = client_enable;
               idx_d   = '0;
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            if (found) begin
               grant_d = sel_idx;
               cnt_d   = '0;
               state_d = S_DRAW;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DRAW: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A finish seen in the first two grant cycles is left over from the last frame.
            if (fin_sel && (cnt_q >= CNT_FIN_MIN)) begin
               state_d = S_GAP;
            end else if (cnt_q == CNT_LAST) begin
               terr_d  = terr_d | grant_oh;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            idx_d   = grant_q + IDX_W'(1);
            state_d = (grant_q == IDX_LAST) ? S_DONE : S_SELECT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         terr_q  <= '0;
         ovr_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         terr_q  <= terr_d;
         ovr_q   <= ovr_d;
         x_q     <= x_sel;
         y_q     <= y_sel;
         color_q <= color_sel;
      end
   end

   // Decoded straight from state so an asynchronous reset drops the grant at once.
   assign client_draw = (state_q == S_DRAW) ? grant_oh : '0;
   assign plot        = (state_q == S_DRAW) && (cnt_q != '0);
   assign busy        = (state_q != S_IDLE);
   assign frame_done  = (state_q == S_DONE);
   assign x           = x_q;
   assign y           = y_q;
   assign color       = color_q;
   assign timeout_err = terr_q;
   assign overrun     = ovr_q;

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Frame-level sequencer for the shared VGA pixel-write port.
- On each frame tick, grants the port to up to NUM_CLIENTS drawing engines (catcher, falling squares, score) in fixed index order.
- Holds each client's draw level until that client reports finish_drawing, and muxes the granted client's x/y/color onto a single plot interface.
- Sits between the drawing engines and the VGA adapter; includes a per-client watchdog and overrun detection.

Parameters:
- NUM_CLIENTS, 3: number of drawing engines; client 0 has highest priority and is drawn first.
- TIMEOUT_CYCLES, 4096: maximum cycles a client may hold the grant before forced release.
- CNT_W, 12: width of the grant cycle counter; must satisfy 2^CNT_W >= TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse that starts a frame pass.
- client_enable  in  NUM_CLIENTS  bit k=1 includes client k in the pass.
- clear_err  in  1  pulse that clears the sticky error flags.
- client_finish  in  NUM_CLIENTS  finish_drawing from each client.
- client_x  in  8*NUM_CLIENTS  packed x; client k occupies [8k+7:8k].
- client_y  in  7*NUM_CLIENTS  packed y.
- client_color  in  3*NUM_CLIENTS  packed color.
- client_draw  out  NUM_CLIENTS  draw level to each client; at most one bit high (one-hot or zero).
- x  out  8  pixel x to VGA.
- y  out  7  pixel y to VGA.
- color  out  3  pixel color to VGA.
- plot  out  1  VGA write enable.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at end of pass.
- timeout_err  out  NUM_CLIENTS  sticky; bit k set if client k was force-released.
- overrun  out  1  sticky; frame_tick arrived while not IDLE.

Behaviour:
- Reset (asynchronous, reset==0): state=IDLE; all outputs 0; grant index 0; counter 0; latched enable mask 0. Reset mid-draw drops client_draw immediately (asynchronously).
- States: IDLE, SELECT, DRAW, GAP, DONE.
- IDLE:
  - frame_tick=1 latches client_enable into mask; next state SELECT.
  - frame_tick=0 stays in IDLE.
- SELECT: pick the lowest index k >= current index with mask[k]=1.
  - Found: grant=k, counter=0, next state DRAW.
  - None: next state DONE.
  - Index starts at 0 each frame.
- DRAW:
  - client_draw[k]=1 on every DRAW cycle; counter increments each cycle.
  - x/y/color register the client-k slice every cycle (1-cycle latency).
  - plot=1 on every DRAW cycle with counter >= 1, so the first plotted pixel is the client's output from the first grant cycle.
  - client_finish[k] is ignored while counter < 2; this masks the stale finish left high from the previous frame.
  - client_finish[k]=1 with counter >= 2: next state GAP.
  - counter == TIMEOUT_CYCLES-1 without finish: set timeout_err[k], next state GAP.
- GAP: exactly one cycle with client_draw=0 and plot=0; index=k+1, next state SELECT. If k == NUM_CLIENTS-1, next state DONE.
- DONE: frame_done=1 for exactly one cycle; next state IDLE.
- frame_tick in any state other than IDLE: ignored; sets overrun.
- clear_err and a new error event in the same cycle: the set wins.
- client_enable changes mid-pass: no effect until the next frame_tick.
- Empty mask: IDLE -> SELECT -> DONE; frame_done pulses 2 cycles after frame_tick; no plot.
- plot is never asserted in IDLE, SELECT, GAP or DONE.

Test Plan:
- Single client, mask=001: client raises finish after 3*119 cycles -> client_draw[0] high 358 cycles; plot high counter 1..end; frame_done one pulse; busy low afterwards.
- Three clients, mask=111, each finishing after 10 cycles -> grants in order 0,1,2 with a 1-cycle all-zero draw gap between each; x equals the granted slice delayed 1 cycle; exactly one frame_done.
- Stale finish: client_finish[1] held high before grant, mask=010 -> no release at counter 0/1; release only once finish is seen with counter >= 2 (finish first drops, then rises).
- Timeout with TIMEOUT_CYCLES=16 and client 2 never finishing -> release after 16 DRAW cycles; timeout_err=100; clear_err clears it.
- Overrun: frame_tick during DRAW -> overrun=1 and pass continues unchanged; mask=000 tick -> frame_done 2 cycles later with no plot.
- Reset asserted mid-DRAW on client 1 -> client_draw, plot, busy go to 0 without waiting for a clock edge; after release, the next frame_tick starts at client 0.
